// File: rtl/fpu_mult_arbiter_if.sv
// Request, response and multiplier-side signals of the FP16 multiplier arbiter.
// slave = arbiter side, master = requesters plus the multiplier instance.
interface fpu_mult_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_result;
    logic                  rsp_err;

    logic                  mul_valid_in;
    logic [15:0]           mul_a;
    logic [15:0]           mul_b;
    logic                  mul_valid_out;
    logic [15:0]           mul_result;

    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_valid_out, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
        output mul_valid_in, mul_a, mul_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_valid_out, mul_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
        input  mul_valid_in, mul_a, mul_b, busy
    );
endinterface

// File: rtl/fpu_mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP16 multiplier among NUM_REQ requesters,
// with a registered tagged response channel and a timeout watchdog.
module fpu_mult_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    fpu_mult_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ID_W-1:0]    pick;
    logic [NUM_REQ-1:0] pick_oh;
    logic               any_valid;
    int                 idx;

    // Scan from farthest to nearest so the nearest valid after last_grant wins.
    always_comb begin
        pick    = '0;
        pick_oh = '0;
        idx     = 0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = (int'(last_grant_q) + k) % int'(NUM_REQ);
            if (bus.req_valid[idx]) begin
                pick         = ID_W'(idx);
                pick_oh      = '0;
                pick_oh[idx] = 1'b1;
            end
        end
    end

    assign any_valid = |bus.req_valid;
    // No grant while reset is held, since the FSM would not accept the transfer.
    assign bus.req_ready = (state_q == StIdle && !rst) ? pick_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            last_grant_q     <= ID_W'(NUM_REQ - 1);
            cnt_q            <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_result   <= '0;
            bus.rsp_err      <= 1'b0;
            bus.mul_valid_in <= 1'b0;
            bus.mul_a        <= '0;
            bus.mul_b        <= '0;
            bus.busy         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        bus.mul_a        <= bus.req_a[16*int'(pick) +: 16];
                        bus.mul_b        <= bus.req_b[16*int'(pick) +: 16];
                        bus.rsp_id       <= pick;
                        last_grant_q     <= pick;
                        bus.mul_valid_in <= 1'b1;
                        bus.busy         <= 1'b1;
                        state_q          <= StIssue;
                    end
                end
                StIssue: begin
                    bus.mul_valid_in <= 1'b0;
                    cnt_q            <= '0;
                    state_q          <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A real result takes priority over the watchdog firing in the same cycle.
                    if (bus.mul_valid_out) begin
                        bus.rsp_result <= bus.mul_result;
                        bus.rsp_err    <= 1'b0;
                        bus.rsp_valid  <= 1'b1;
                        state_q        <= StResp;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        bus.rsp_result <= 16'h7E00;
                        bus.rsp_err    <= 1'b1;
                        bus.rsp_valid  <= 1'b1;
                        state_q        <= StResp;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Directed bench for fpu_mult_arbiter with a 5-stage multiplier stand-in.
module tb_fpu_mult_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    fpu_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    fpu_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: known products of the operand pairs used below.
    function automatic logic [15:0] mock_mul(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h4000_3C00: return 16'h4000;
            32'h4000_4000: return 16'h4400;
            32'h4000_4400: return 16'h4800;
            32'h4000_4800: return 16'h4C00;
            32'h3C00_4000: return 16'h4000;
            default:       return 16'h0BAD;
        endcase
    endfunction

    logic [4:0]  pipe_v = '0;
    logic [15:0] pipe_r [5];
    logic        mul_en    = 1'b1;
    logic        force_vo  = 1'b0;
    logic [15:0] force_res = '0;
    int          issue_cnt = 0;

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[3:0], bus.mul_valid_in};
        pipe_r[0] <= mock_mul(bus.mul_a, bus.mul_b);
        for (int i = 1; i < 5; i++) pipe_r[i] <= pipe_r[i-1];
        if (bus.mul_valid_in === 1'b1) issue_cnt <= issue_cnt + 1;
    end

    assign bus.mul_valid_out = force_vo | (mul_en & pipe_v[4]);
    assign bus.mul_result    = force_vo ? force_res : pipe_r[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int ic;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.req_a[16*i +: 16] = 16'h4000;
            bus.req_b[16*i +: 16] = 16'h3C00 + 16'(i) * 16'h0400;
        end
        step();
        do_reset();

        check("rst_busy",      32'(bus.busy),         32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid),    32'h0);
        check("rst_mul_vin",   32'(bus.mul_valid_in), 32'h0);
        check("rst_mul_a",     32'(bus.mul_a),        32'h0);
        check("rst_rsp_res",   32'(bus.rsp_result),   32'h0);

        // Single request from requester 0: 1.0 * 2.0
        bus.req_a[15:0] = 16'h3C00;
        bus.req_b[15:0] = 16'h4000;
        bus.req_valid   = 4'b0001;
        #1;
        check("t1_grant", 32'(bus.req_ready), 32'h1);
        ic = issue_cnt;
        step();
        bus.req_valid = '0;
        check("t1_issue_pulse", 32'(bus.mul_valid_in), 32'h1);
        check("t1_mul_a",       32'(bus.mul_a),        32'h3C00);
        check("t1_mul_b",       32'(bus.mul_b),        32'h4000);
        wait_rsp(n);
        check("t1_latency", 32'(n),                 32'd6);
        check("t1_rsp_id",  32'(bus.rsp_id),        32'h0);
        check("t1_result",  32'(bus.rsp_result),    32'h4000);
        check("t1_err",     32'(bus.rsp_err),       32'h0);
        check("t1_issues",  32'(issue_cnt - ic),    32'd1);
        step();
        check("t1_busy_low", 32'(bus.busy),      32'h0);
        check("t1_rsp_drop", 32'(bus.rsp_valid), 32'h0);

        // All four requesting continuously: grants 0,1,2,3,0
        bus.req_a[15:0] = 16'h4000;
        bus.req_b[15:0] = 16'h3C00;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t2_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
            ic = issue_cnt;
            step();
            check("t2_mul_b", 32'(bus.mul_b), 32'h3C00 + 32'(k % 4) * 32'h0400);
            wait_rsp(n);
            check("t2_latency", 32'(n),              32'd6);
            check("t2_rsp_id",  32'(bus.rsp_id),     32'(k % 4));
            check("t2_result",  32'(bus.rsp_result), 32'h4000 + 32'(k % 4) * 32'h0400);
            check("t2_issues",  32'(issue_cnt - ic), 32'd1);
            step();
        end
        bus.req_valid = '0;

        // Back-pressure: last grant 0, requester 2 served, requester 3 left waiting
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        #1;
        check("t3_grant", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = 4'b1000;
        wait_rsp(n);
        check("t3_latency", 32'(n), 32'd6);
        ic = issue_cnt;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t3_hold_valid",  32'(bus.rsp_valid),  32'h1);
            check("t3_hold_id",     32'(bus.rsp_id),     32'h2);
            check("t3_hold_result", 32'(bus.rsp_result), 32'h4800);
            check("t3_no_grant",    32'(bus.req_ready),  32'h0);
        end
        check("t3_no_issue", 32'(issue_cnt - ic), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        check("t3_idle_busy", 32'(bus.busy),      32'h0);
        check("t3_idle_rsp",  32'(bus.rsp_valid), 32'h0);
        check("t3_next_req",  32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = '0;
        check("t3_next_issue", 32'(bus.mul_valid_in), 32'h1);
        check("t3_next_b",     32'(bus.mul_b),        32'h4800);
        wait_rsp(n);
        check("t3_next_id",     32'(bus.rsp_id),     32'h3);
        check("t3_next_result", 32'(bus.rsp_result), 32'h4C00);
        step();

        // Timeout: multiplier silent, requester 0 (last grant 3)
        mul_en        = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        check("t4_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        wait_rsp(n);
        check("t4_latency", 32'(n),              32'(TIMEOUT + 1));
        check("t4_result",  32'(bus.rsp_result), 32'h7E00);
        check("t4_err",     32'(bus.rsp_err),    32'h1);
        check("t4_id",      32'(bus.rsp_id),     32'h0);
        step();
        mul_en        = 1'b1;
        bus.req_valid = 4'b0010;
        #1;
        check("t4_resume_grant", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        wait_rsp(n);
        check("t4_resume_result", 32'(bus.rsp_result), 32'h4400);
        check("t4_resume_err",    32'(bus.rsp_err),    32'h0);
        step();

        // Result and timeout coincide: result wins
        mul_en        = 1'b0;
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        repeat (TIMEOUT) step();
        check("t5_not_yet", 32'(bus.rsp_valid), 32'h0);
        force_vo  = 1'b1;
        force_res = 16'h1234;
        step();
        force_vo = 1'b0;
        check("t5_valid",  32'(bus.rsp_valid),  32'h1);
        check("t5_result", 32'(bus.rsp_result), 32'h1234);
        check("t5_err",    32'(bus.rsp_err),    32'h0);
        check("t5_id",     32'(bus.rsp_id),     32'h2);
        step();
        mul_en = 1'b1;

        // Reset while in WAIT, then stray strobes in IDLE
        bus.req_valid = 4'b1000;
        step();
        bus.req_valid = '0;
        check("t6_issue", 32'(bus.mul_valid_in), 32'h1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy",   32'(bus.busy),         32'h0);
        check("t6_rsp_v",  32'(bus.rsp_valid),    32'h0);
        check("t6_rsp_id", 32'(bus.rsp_id),       32'h0);
        check("t6_res",    32'(bus.rsp_result),   32'h0);
        check("t6_err",    32'(bus.rsp_err),      32'h0);
        check("t6_mvin",   32'(bus.mul_valid_in), 32'h0);
        check("t6_mul_a",  32'(bus.mul_a),        32'h0);
        check("t6_mul_b",  32'(bus.mul_b),        32'h0);
        force_vo  = 1'b1;
        force_res = 16'h5555;
        step();
        force_vo = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) n++;
            step();
        end
        check("t6_no_rsp", 32'(n), 32'd0);
        bus.req_a[15:0] = 16'h3C00;
        bus.req_b[15:0] = 16'h4000;
        bus.req_valid   = 4'b0011;
        #1;
        check("t6_first_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        wait_rsp(n);
        check("t6_latency", 32'(n),              32'd6);
        check("t6_result",  32'(bus.rsp_result), 32'h4000);
        check("t6_id",      32'(bus.rsp_id),     32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
